// File: rtl/fsqrt_pkg.sv
// Shared constants, state encodings, float field layout and operand classifiers
// for the fsqrt_nr square-root unit.
package fsqrt_pkg;

  localparam int unsigned FRAC_DEF = 30;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;
  localparam logic [7:0]  BIAS = 8'd127;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SEED   = 3'd1;
  localparam logic [2:0] MUL_RR = 3'd2;
  localparam logic [2:0] MUL_AT = 3'd3;
  localparam logic [2:0] MUL_RT = 3'd4;
  localparam logic [2:0] MUL_AR = 3'd5;
  localparam logic [2:0] ROUND  = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  function automatic logic is_zero_or_denorm(input logic [7:0] e);
    return e == 8'd0;
  endfunction

  function automatic logic is_nan(input logic [7:0] e, input logic [22:0] m);
    return (e == 8'hFF) && (m != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [7:0] e, input logic [22:0] m);
    return (e == 8'hFF) && (m == 23'd0);
  endfunction

endpackage

// File: rtl/finvsqrt.sv
// Combinational 1/sqrt seed for operands in [1,4): bit-trick estimate refined
// by two Newton steps in Q2.23, repacked as a positive single.
module finvsqrt (
  input  logic [31:0] x,
  output logic [31:0] rsqrt_c
);
  localparam int unsigned QF = 23;
  localparam int unsigned QW = 25;
  localparam int unsigned PW = 2 * QW;
  localparam logic [31:0]   MAGIC = 32'h5F3759DF;
  localparam logic [QW-1:0] THREE = QW'(3) << QF;

  function automatic logic [QW-1:0] nr_step(input logic [QW-1:0] a, input logic [QW-1:0] r);
    logic [PW-1:0] p;
    logic [QW-1:0] rr, t, h;
    p  = PW'(r) * PW'(r);
    rr = QW'(p >> QF);
    p  = PW'(a) * PW'(rr);
    t  = QW'(p >> QF);
    h  = (t > THREE) ? '0 : THREE - t;
    p  = PW'(r) * PW'(h);
    return QW'(p >> (QF + 1));
  endfunction

  logic [31:0]   y0;
  logic [7:0]    e0, shamt, e_out;
  logic [22:0]   m0, m_out;
  logic [QW-1:0] a_fx, r0, r2;

  always_comb begin
    y0    = MAGIC - (x >> 1);
    e0    = 8'(y0 >> 23);
    m0    = 23'(y0);
    shamt = 8'd127 - e0;
    a_fx  = (x[30:23] == 8'd128) ? (QW'({1'b1, x[22:0]}) << 1) : QW'({1'b1, x[22:0]});
    r0    = QW'({1'b1, m0}) >> shamt;
    r2    = nr_step(a_fx, nr_step(a_fx, r0));
    // Refined estimate lies in (0.48, 1]; normalise on its leading one.
    if (r2[23]) begin
      e_out = 8'd127; m_out = 23'(r2);
    end else if (r2[22]) begin
      e_out = 8'd126; m_out = 23'(r2 << 1);
    end else if (r2[21]) begin
      e_out = 8'd125; m_out = 23'(r2 << 2);
    end else begin
      e_out = 8'd124; m_out = 23'(r2 << 3);
    end
    rsqrt_c = {1'b0, e_out, m_out};
  end

endmodule

// File: rtl/fsqrt_fxmul.sv
// Unsigned Q2.FRAC multiply, truncated back to Q2.FRAC.
module fsqrt_fxmul #(
  parameter int unsigned FRAC = 30
) (
  input  logic [FRAC+1:0] p,
  input  logic [FRAC+1:0] q,
  output logic [FRAC+1:0] prod_c
);
  localparam int unsigned W = FRAC + 2;

  logic [2*W-1:0] full_c;

  always_comb begin
    full_c = (2*W)'(p) * (2*W)'(q);
    prod_c = W'(full_c >> FRAC);
  end

endmodule

// File: rtl/fsqrt_nr.sv
// Sequential single-precision sqrt: seed from finvsqrt, ITER Newton steps on a
// shared Q2.FRAC multiplier, then s = a*r, round-to-nearest-even and repack.
module fsqrt_nr
  import fsqrt_pkg::*;
#(
  parameter int unsigned ITER = 1,
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        busy
);
  localparam int unsigned W = FRAC + 2;
  localparam logic [W-1:0] THREE = W'(3) << FRAC;

  logic [2:0]   state_q, state_d;
  logic [1:0]   it_q, it_d;
  logic [W-1:0] a_q, a_d, r_q, r_d, t_q, t_d;
  logic [7:0]   exp_q, exp_d;
  logic [31:0]  seed_op_q, seed_op_d, y_q, y_d;
  logic         out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;

  logic [31:0]  seed_c;
  logic [W-1:0] mul_p, mul_q, prod_c, h;
  fp32_t        fx;
  logic signed [9:0] e_unb, e_even;
  logic         odd, guard, up;
  logic [7:0]   res_exp, seed_exp, exp_adj, exp_r;
  logic [22:0]  seed_man, mant, man_r;
  logic [W-1:0] s_n, lo;
  logic [24:0]  sum;

  finvsqrt u_seed (.x(seed_op_q), .rsqrt_c(seed_c));

  fsqrt_fxmul #(.FRAC(FRAC)) u_mul (.p(mul_p), .q(mul_q), .prod_c(prod_c));

  // Operand steering for the single shared multiplier.
  always_comb begin
    h     = (t_q > THREE) ? '0 : THREE - t_q;
    mul_p = '0;
    mul_q = '0;
    case (state_q)
      MUL_RR:  begin mul_p = r_q; mul_q = r_q; end
      MUL_AT:  begin mul_p = a_q; mul_q = t_q; end
      MUL_RT:  begin mul_p = r_q; mul_q = h;   end
      MUL_AR:  begin mul_p = a_q; mul_q = r_q; end
      default: begin mul_p = '0;  mul_q = '0;  end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    it_d      = it_q;
    a_d       = a_q;
    r_d       = r_q;
    t_d       = t_q;
    exp_d     = exp_q;
    seed_op_d = seed_op_q;
    y_d       = y_q;

    fx       = fp32_t'(x);
    e_unb    = $signed({2'b00, fx.exp}) - 10'sd127;
    odd      = e_unb[0];
    e_even   = odd ? e_unb - 10'sd1 : e_unb;
    res_exp  = 8'((e_even >>> 1) + 10'sd127);
    seed_exp = 8'(seed_c >> 23);
    seed_man = 23'(seed_c);

    // Truncation can leave s just under 1.0; renormalise before rounding.
    s_n     = t_q[FRAC] ? t_q : t_q << 1;
    exp_adj = t_q[FRAC] ? exp_q : exp_q - 8'd1;
    mant    = 23'(s_n >> (FRAC - 23));
    guard   = s_n[FRAC-24];
    lo      = W'(s_n << (W - (FRAC - 24)));
    up      = guard && ((lo != '0) || mant[0]);
    sum     = {2'b01, mant} + 25'(up);
    man_r   = sum[24] ? 23'd0 : 23'(sum);
    exp_r   = sum[24] ? exp_adj + 8'd1 : exp_adj;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_nan(fx.exp, fx.man) || (fx.sign && !is_zero_or_denorm(fx.exp))) begin
            y_d = QNAN; state_d = DONE;
          end else if (is_zero_or_denorm(fx.exp)) begin
            y_d = {fx.sign, 31'd0}; state_d = DONE;
          end else if (is_inf(fx.exp, fx.man)) begin
            y_d = PINF; state_d = DONE;
          end else begin
            a_d       = odd ? (W'({1'b1, fx.man}) << (FRAC - 22)) : (W'({1'b1, fx.man}) << (FRAC - 23));
            seed_op_d = {1'b0, odd ? 8'd128 : BIAS, fx.man};
            exp_d     = res_exp;
            it_d      = 2'd0;
            state_d   = SEED;
          end
        end
      end
      SEED: begin
        r_d     = (W'({1'b1, seed_man}) << (FRAC - 23)) >> (BIAS - seed_exp);
        state_d = MUL_RR;
      end
      MUL_RR: begin t_d = prod_c; state_d = MUL_AT; end
      MUL_AT: begin t_d = prod_c; state_d = MUL_RT; end
      MUL_RT: begin
        r_d = prod_c >> 1;
        if (it_q == 2'(ITER - 1)) begin
          state_d = MUL_AR;
        end else begin
          it_d    = 2'(it_q + 2'd1);
          state_d = MUL_RR;
        end
      end
      MUL_AR: begin t_d = prod_c; state_d = ROUND; end
      ROUND:  begin y_d = {1'b0, exp_r, man_r}; state_d = DONE; end
      DONE:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      it_q        <= '0;
      a_q         <= '0;
      r_q         <= '0;
      t_q         <= '0;
      exp_q       <= '0;
      seed_op_q   <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      it_q        <= it_d;
      a_q         <= a_d;
      r_q         <= r_d;
      t_q         <= t_d;
      exp_q       <= exp_d;
      seed_op_q   <= seed_op_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fsqrt_nr.sv
// Directed bench for fsqrt_nr: one instance with ITER=1 (index 0) and one with
// ITER=3 (index 1); latency counted in clock edges after the accept edge.
module tb_fsqrt_nr;

  logic        clk;
  logic        rst;
  logic        iv  [2];
  logic [31:0] xx  [2];
  logic        orr [2];
  logic        ov  [2];
  logic        ir  [2];
  logic        bz  [2];
  logic [31:0] yy  [2];

  int nvec = 0;
  int nmis = 0;

  fsqrt_nr #(.ITER(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .x(xx[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .y(yy[0]), .busy(bz[0])
  );

  fsqrt_nr #(.ITER(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .x(xx[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .y(yy[1]), .busy(bz[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact sqrt in double precision, rounded to nearest-even single.
  function automatic logic [31:0] sqrt_model(input logic [31:0] xin);
    logic [63:0] db;
    logic [23:0] m;
    logic [10:0] e11;
    logic        g, st;
    real         r;
    db  = {1'b0, 11'({3'b000, xin[30:23]}) + 11'd896, xin[22:0], 29'd0};
    r   = $sqrt($bitstoreal(db));
    db  = $realtobits(r);
    m   = {1'b0, db[51:29]};
    g   = db[28];
    st  = |db[27:0];
    e11 = db[62:52];
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m   = '0;
      e11 = e11 + 11'd1;
    end
    return {1'b0, 8'(e11 - 11'd896), m[22:0]};
  endfunction

  // Issue one operand with out_ready high; lat = edges after accept, -1 on timeout.
  task automatic run_op(input int d, input logic [31:0] xin, output logic [31:0] yout, output int lat);
    iv[d]  = 1'b1;
    xx[d]  = xin;
    orr[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    lat   = -1;
    yout  = '0;
    if (ov[d]) begin
      lat  = 0;
      yout = yy[d];
    end
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (ov[d]) begin
        lat  = c;
        yout = yy[d];
      end
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b1; xx[d] = 32'h40800000; orr[d] = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (ov[d] !== 1'b0) begin
          nmis++; $display("FAIL reset_out_valid dut%0d cyc%0d got %b want 0", d, c, ov[d]);
        end
        nvec++;
        if (bz[d] !== 1'b0) begin
          nmis++; $display("FAIL reset_busy dut%0d cyc%0d got %b want 0", d, c, bz[d]);
        end
        nvec++;
        if (yy[d] !== 32'h0) begin
          nmis++; $display("FAIL reset_y dut%0d cyc%0d got %h want 00000000", d, c, yy[d]);
        end
      end
    end
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0;
      nvec++;
      if (ir[d] !== 1'b1) begin
        nmis++; $display("FAIL reset_in_ready dut%0d got %b want 1", d, ir[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] xin [3];
    logic [31:0] exp [3];
    logic [31:0] yo;
    int lat, diff;
    xin[0] = 32'h40800000; exp[0] = 32'h40000000;
    xin[1] = 32'h41100000; exp[1] = 32'h40400000;
    xin[2] = 32'h3F800000; exp[2] = 32'h3F800000;
    for (int k = 0; k < 3; k++) begin
      run_op(0, xin[k], yo, lat);
      nvec++;
      if (lat !== 6) begin
        nmis++; $display("FAIL basic_latency x=%h got %0d want 6", xin[k], lat);
      end
      diff = int'(yo) - int'(exp[k]);
      nvec++;
      if (diff > 1 || diff < -1) begin
        nmis++; $display("FAIL basic_value x=%h got %h want %h (+-1 ulp)", xin[k], yo, exp[k]);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] xin [5];
    logic [31:0] exp [5];
    logic [31:0] yo;
    int lat;
    xin[0] = 32'h80000000; exp[0] = 32'h80000000;
    xin[1] = 32'h00000001; exp[1] = 32'h00000000;
    xin[2] = 32'hBF800000; exp[2] = 32'h7FC00000;
    xin[3] = 32'h7F800000; exp[3] = 32'h7F800000;
    xin[4] = 32'h7FA00000; exp[4] = 32'h7FC00000;
    for (int k = 0; k < 5; k++) begin
      run_op(0, xin[k], yo, lat);
      nvec++;
      if (lat !== 0) begin
        nmis++; $display("FAIL special_latency x=%h got %0d want 0", xin[k], lat);
      end
      nvec++;
      if (yo !== exp[k]) begin
        nmis++; $display("FAIL special_value x=%h got %h want %h", xin[k], yo, exp[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] yhold;
    int lat, diff;
    iv[0] = 1'b1; xx[0] = 32'h40800000; orr[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    lat   = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (ov[0]) lat = c;
    end
    nvec++;
    if (lat !== 6) begin
      nmis++; $display("FAIL bp_latency got %0d want 6", lat);
    end
    yhold = yy[0];
    diff  = int'(yhold) - int'(32'h40000000);
    nvec++;
    if (diff > 1 || diff < -1) begin
      nmis++; $display("FAIL bp_value got %h want 40000000 (+-1 ulp)", yhold);
    end
    iv[0] = 1'b1; xx[0] = 32'h3F800000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      nvec++;
      if (ov[0] !== 1'b1) begin
        nmis++; $display("FAIL bp_out_valid cyc%0d got %b want 1", c, ov[0]);
      end
      nvec++;
      if (yy[0] !== yhold) begin
        nmis++; $display("FAIL bp_y_stable cyc%0d got %h want %h", c, yy[0], yhold);
      end
      nvec++;
      if (ir[0] !== 1'b0) begin
        nmis++; $display("FAIL bp_in_ready cyc%0d got %b want 0", c, ir[0]);
      end
    end
    iv[0] = 1'b0; orr[0] = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
      nmis++; $display("FAIL bp_retire got ov=%b ir=%b busy=%b want ov=0 ir=1 busy=0", ov[0], ir[0], bz[0]);
    end
  endtask

  task automatic test_sweep(input int d, input int want_lat);
    logic [31:0] xin, yo, exp;
    logic [7:0]  e;
    int lat, diff;
    for (int ei = 0; ei < 2; ei++) begin
      e = (ei == 0) ? 8'd127 : 8'd128;
      for (int i = 0; i < 16; i++) begin
        xin = {1'b0, e, 23'(i << 18)};
        exp = sqrt_model(xin);
        run_op(d, xin, yo, lat);
        nvec++;
        if (lat !== want_lat) begin
          nmis++; $display("FAIL sweep_latency dut%0d x=%h got %0d want %0d", d, xin, lat, want_lat);
        end
        diff = int'(yo) - int'(exp);
        nvec++;
        if (diff > 1 || diff < -1) begin
          nmis++; $display("FAIL sweep_value dut%0d x=%h got %h want %h (+-1 ulp)", d, xin, yo, exp);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; xx[d] = '0; orr[d] = 1'b1;
    end
    test_reset();
    test_basic();
    test_specials();
    test_backpressure();
    test_sweep(0, 6);
    test_sweep(1, 12);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
